// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch stage: holds the PC and fetches one instruction at a time for decode/execute.
// Latency: at least 3 cycles from a commit to the next instr_valid (HOLD->REQ->WAIT->HOLD).
// Backpressure: the request stays asserted with a stable address until imem_ready; only one fetch is outstanding.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   pc_src, branch_taken,       next-PC selection from the control unit and datapath,
//   branch_target, jump_target  sampled only on a commit while an instruction is held
//   commit                      retire pulse from execute
//   imem_req, imem_addr         fetch request / address to instruction memory
//   imem_ready                  memory accepts the request this cycle
//   imem_rvalid, imem_rdata     instruction response
//   instr, opcode, instr_valid  held instruction and its opcode field for decode
//   pc, pc_plus4                address of held instruction and its link value
//   misaligned_fault            sticky flag: a computed next PC was not word aligned
//   retired                     count of retired instructions (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_fault,
    output logic [31:0] retired
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;

    // Next-PC mux. The reserved encoding 11 falls through to sequential.
    // JAL/JALR targets have bit 0 forced low here so the datapath does not
    // have to; bit 1 is kept so a misaligned jump is still detected.
    always_comb begin
        next_pc = pc_plus4_w;
        case (pc_src)
            PC_SRC_BRANCH: begin
                if (branch_taken) begin
                    next_pc = branch_target;
                end
            end
            PC_SRC_JUMP: begin
                next_pc = jump_target & 32'hFFFF_FFFE;
            end
            default: begin
                next_pc = pc_plus4_w;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            retired_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    // Response data is captured only in WAIT, so a response in the same
    // cycle as acceptance, in HOLD, or arriving late after a reset is
    // dropped. Commit is honoured only in HOLD.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        fault_d   = fault_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (commit) begin
                    // A faulting instruction has still retired.
                    retired_d = retired_q + 32'd1;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req         = (state_q == ST_REQ);
    assign instr_valid      = (state_q == ST_HOLD);
    assign imem_addr        = pc_q;
    assign pc               = pc_q;
    assign pc_plus4         = pc_plus4_w;
    assign instr            = instr_q;
    assign opcode           = instr_q[6:0];
    assign misaligned_fault = fault_q;
    assign retired          = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned_fault;
    logic [31:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_src           (pc_src),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump_target      (jump_target),
        .commit           (commit),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .opcode           (opcode),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .misaligned_fault (misaligned_fault),
        .retired          (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From REQ: accepted on the first edge, response on the next edge.
    task automatic fetch(input logic [31:0] d);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic do_commit(input logic [1:0] src, input logic tk,
                             input logic [31:0] bt, input logic [31:0] jt);
        pc_src        = src;
        branch_taken  = tk;
        branch_target = bt;
        jump_target   = jt;
        commit        = 1'b1;
        tick();
        commit        = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req"},     32'(imem_req), 32'd0);
        chk({pfx, "_valid"},   32'(instr_valid), 32'd0);
        chk({pfx, "_pc"},      pc, 32'h0000_0100);
        chk({pfx, "_addr"},    imem_addr, 32'h0000_0100);
        chk({pfx, "_instr"},   instr, 32'h0000_0013);
        chk({pfx, "_opcode"},  32'(opcode), 32'h13);
        chk({pfx, "_pcp4"},    pc_plus4, 32'h0000_0104);
        chk({pfx, "_retired"}, retired, 32'd0);
        chk({pfx, "_fault"},   32'(misaligned_fault), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; pc_src = 2'b00; branch_taken = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; commit = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("rst");

        // ---- first fetch ----
        repeat (2) tick();
        rst_n = 1'b1;
        tick();                                   // edge 1: IDLE->REQ
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0100);
        imem_ready = 1'b1;
        tick();                                   // edge 2: REQ->WAIT
        chk("first_wait_req", 32'(imem_req), 32'd0);
        chk("first_wait_valid", 32'(instr_valid), 32'd0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();                                   // edge 3: WAIT->HOLD
        imem_rvalid = 1'b0;
        chk("first_valid",  32'(instr_valid), 32'd1);
        chk("first_instr",  instr, 32'h0050_0093);
        chk("first_opcode", 32'(opcode), 32'h13);
        chk("first_pcp4",   pc_plus4, 32'h0000_0104);

        // ---- sequential commit, 3-cycle gap ----
        do_commit(2'b00, 1'b0, 32'h0, 32'h0);     // edge 1
        chk("seq_valid_e1", 32'(instr_valid), 32'd0);
        chk("seq_addr",     imem_addr, 32'h0000_0104);
        chk("seq_req",      32'(imem_req), 32'd1);
        chk("seq_retired",  retired, 32'd1);
        imem_ready = 1'b1;
        tick();                                   // edge 2
        chk("seq_valid_e2", 32'(instr_valid), 32'd0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_8113;
        tick();                                   // edge 3
        imem_rvalid = 1'b0;
        chk("seq_valid_e3", 32'(instr_valid), 32'd1);
        chk("seq_instr",    instr, 32'h0010_8113);

        // ---- branch not taken / taken ----
        do_commit(2'b01, 1'b0, 32'h0000_0080, 32'h0);
        chk("bnt_pc", pc, 32'h0000_0108);
        chk("bnt_retired", retired, 32'd2);
        fetch(32'h0000_0063);
        do_commit(2'b01, 1'b1, 32'h0000_0080, 32'h0);
        chk("bt_pc", pc, 32'h0000_0080);
        chk("bt_retired", retired, 32'd3);
        fetch(32'h0000_0067);

        // ---- reserved encoding behaves as sequential ----
        do_commit(2'b11, 1'b1, 32'h0000_0400, 32'h0000_0400);
        chk("rsv_pc", pc, 32'h0000_0084);
        fetch(32'h0000_0067);

        // ---- JALR with odd target clears bit 0 ----
        do_commit(2'b10, 1'b0, 32'h0, 32'h0000_0201);
        chk("jalr_pc", pc, 32'h0000_0200);
        chk("jalr_fault", 32'(misaligned_fault), 32'd0);
        chk("jalr_retired", retired, 32'd5);
        fetch(32'h0000_0013);

        // ---- backpressure and long latency ----
        do_commit(2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req",  32'(imem_req), 32'd1);
            chk("bp_addr", imem_addr, 32'h0000_0204);
            tick();
        end
        chk("bp_req_end", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAAD_F00D; // same cycle as accept: not sampled
        tick();                                   // accept edge
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        chk("bp_wait_instr", instr, 32'h0000_0013);
        commit = 1'b1;
        tick();                                   // commit in WAIT, ignored
        commit = 1'b0;
        chk("wait_commit_retired", retired, 32'd6);
        chk("wait_commit_pc", pc, 32'h0000_0204);
        chk("wait_commit_valid", 32'(instr_valid), 32'd0);
        chk("wait_commit_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        chk("bp_latency_valid", 32'(instr_valid), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0040_0113;
        tick();                                   // 4 cycles after accept
        imem_rvalid = 1'b0;
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_instr", instr, 32'h0040_0113);
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();                                   // spurious response in HOLD
        imem_rvalid = 1'b0;
        chk("spur_instr", instr, 32'h0040_0113);
        chk("spur_valid", 32'(instr_valid), 32'd1);

        // ---- wrap at top of address space ----
        do_commit(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFD);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_pcp4", pc_plus4, 32'h0000_0000);
        fetch(32'h0000_0013);
        do_commit(2'b00, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_fault", 32'(misaligned_fault), 32'd0);
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_retired", retired, 32'd8);
        fetch(32'h0000_0013);

        // ---- misaligned jump -> FAULT ----
        do_commit(2'b10, 1'b0, 32'h0, 32'h0000_0202);
        chk("flt_fault", 32'(misaligned_fault), 32'd1);
        chk("flt_pc", pc, 32'h0000_0000);
        chk("flt_req", 32'(imem_req), 32'd0);
        chk("flt_valid", 32'(instr_valid), 32'd0);
        chk("flt_retired", retired, 32'd9);
        imem_ready = 1'b1; imem_rvalid = 1'b1;
        do_commit(2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        chk("flt_sticky", 32'(misaligned_fault), 32'd1);
        chk("flt_absorb_req", 32'(imem_req), 32'd0);
        chk("flt_absorb_retired", retired, 32'd9);

        // ---- reset out of FAULT, then reset while in WAIT ----
        rst_n = 1'b0;
        #1;
        chk("flt_rst_fault", 32'(misaligned_fault), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();                                   // IDLE->REQ
        imem_ready = 1'b1;
        tick();                                   // REQ->WAIT
        imem_ready = 1'b0;
        chk("rst2_inwait_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // pending late response
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("rstw");
        tick();
        rst_n = 1'b1;
        tick();                                   // IDLE->REQ, late rvalid still high
        chk("restart_req",   32'(imem_req), 32'd1);
        chk("restart_addr",  imem_addr, 32'h0000_0100);
        chk("late_instr",    instr, 32'h0000_0013);
        tick();                                   // REQ, not ready, rvalid ignored
        imem_rvalid = 1'b0;
        chk("late_instr2",   instr, 32'h0000_0013);
        chk("late_valid",    32'(instr_valid), 32'd0);
        fetch(32'h0050_0093);
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_instr", instr, 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit in the single-cycle RV32I core. Holds the program counter and fetches one instruction at a time from an instruction memory with variable latency. It presents the instruction and its opcode field to decode and execute. When execute retires the instruction, it computes the next PC from the control unit's pc_src encoding and the datapath's branch/jump targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc_src  in  2  next-PC select from control unit: 00=PC+4, 01=branch, 10=JAL/JALR, 11=reserved (treated as 00).
- branch_taken  in  1  branch comparison result; only meaningful when pc_src=01.
- branch_target  in  32  PC+immB from datapath.
- jump_target  in  32  JAL PC+immJ or JALR rs1+immI from datapath; bit 0 is cleared inside this block.
- commit  in  1  single-cycle pulse from execute: current instruction retired, and pc_src/targets are valid this cycle.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction.
- opcode  out  7  instr[6:0], feeds the control unit.
- instr_valid  out  1  instr/opcode/pc valid for decode/execute.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4, used for the JAL/JALR link value.
- misaligned_fault  out  1  sticky: next PC was not 4-byte aligned.
- retired  out  32  count of retired instructions.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: entered only via reset. Goes to REQ on the next clock unconditionally.
- REQ: imem_req=1, imem_addr=pc.
  - If imem_ready=1, go to WAIT.
  - Otherwise remain in REQ; addr stays stable and req is not dropped.
- WAIT: imem_req=0.
  - On imem_rvalid=1: instr<=imem_rdata, go to HOLD.
  - imem_rvalid in any other state is ignored.
- HOLD: instr_valid=1.
  - On commit=1: compute next_pc, increment retired by 1 (wraps modulo 2^32).
  - If next_pc[1:0]==00: pc<=next_pc, go to REQ.
  - Else: pc unchanged, misaligned_fault<=1, go to FAULT.
  - A faulting commit still increments retired.
- commit outside HOLD is ignored: no PC, counter or state change.
- next_pc selection:
  - pc_src=00 or 11: pc+4.
  - pc_src=01: branch_target if branch_taken, else pc+4.
  - pc_src=10: {jump_target[31:1],1'b0}.
- All adds are 32-bit, wrapping modulo 2^32. 32'hFFFF_FFFC+4 yields 0, which is not a fault.
- FAULT: absorbing until reset. imem_req=0, instr_valid=0, misaligned_fault=1.
- Only one fetch is outstanding at a time. No prefetch and no request while in HOLD.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), retired=0, misaligned_fault=0.
  - imem_req=0, instr_valid=0.
  - opcode=7'b0010011, pc_plus4=RESET_PC+4.
- Reset asserted mid-operation (any state, including a pending memory response) returns to IDLE. Late responses arrive in IDLE/REQ and are ignored.
- Output timing:
  - imem_req and instr_valid are decoded from registered state (Moore).
  - pc, instr and retired are registers.
  - opcode and pc_plus4 are combinational from registers.
- First request: first clock edge after rst_n rises moves IDLE->REQ; imem_req is high in the following cycle.
- Minimum commit-to-next-instr_valid latency is 3 cycles, with ready and rvalid each high on first opportunity:
  - edge 1: HOLD->REQ
  - edge 2: REQ->WAIT
  - edge 3: WAIT->HOLD
- imem_rvalid in the same cycle as imem_ready is not sampled; the memory's earliest response is the cycle after acceptance.
- instr, pc and opcode are stable for the entire HOLD residency.

## Test plan
- Reset with RESET_PC=32'h100, ready=1, rvalid one cycle after accept, rdata=32'h00500093:
  - imem_addr=32'h100.
  - instr_valid rises 3 edges after reset release.
  - opcode=7'b0010011, pc_plus4=32'h104.
- Sequential commit, pc_src=00 from pc=32'h100: next imem_addr=32'h104, retired=1. The commit-to-instr_valid gap is exactly 3 cycles.
- Branch: pc_src=01, target=32'h80.
  - branch_taken=0: next pc=pc+4.
  - branch_taken=1: next pc=32'h80.
- JALR: pc_src=10, jump_target=32'h201 gives next pc=32'h200. jump_target=32'h202 gives misaligned_fault=1, FAULT state, imem_req stays 0, and pc is unchanged.
- Backpressure and latency: hold imem_ready=0 for 5 cycles, then rvalid 4 cycles after accept.
  - imem_addr stays stable throughout.
  - A commit pulse during WAIT is ignored (retired unchanged).
  - A spurious rvalid in HOLD does not change instr.
- Reset asserted while in WAIT: outputs return to reset values immediately, and fetch restarts at RESET_PC.
